// File: rtl/tt_bus_pkg.sv
// Shared constants for the TinyTapeout pin-bus responder: FSM encodings,
// address width, pin bit positions and the parity helper.
package tt_bus_pkg;

  localparam int ADDR_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;

  // ui_in bit positions
  localparam int REQ_BIT = 7;
  localparam int WE_BIT  = 6;
  localparam int PAR_BIT = 5;

  // uo_out bit positions
  localparam int ACK_BIT = 0;
  localparam int ERR_BIT = 1;

  // Even parity over data plus parity bit: the XOR of all nine bits must be 0.
  function automatic logic even_parity_ok(input logic [8:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/tt_pin_bus_responder_if.sv
// TinyTapeout user-pin bundle between the host MCU (master) and the
// register-file responder (slave).
interface tt_pin_bus_responder_if;
  // Handshake: host raises ui_in[7] (req) with we/addr/data held stable;
  // responder raises uo_out[0] (ack) once the command is done; host drops req,
  // responder drops ack. uio_out is valid only while uio_oe == 8'hFF.
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  modport master (
    output ui_in, uio_in,
    input  uio_out, uio_oe, uo_out
  );

  modport slave (
    input  ui_in, uio_in,
    output uio_out, uio_oe, uo_out
  );
endinterface

// File: rtl/tt_sync2.sv
// Two-flop synchronizer with synchronous active-low reset for one async bit.
module tt_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic req_s1;
  logic req_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
    end else begin
      req_s1 <= d;
      req_s2 <= req_s1;
    end
  end

  assign q = req_s2;
endmodule

// File: rtl/tt_pin_bus_responder.sv
// 4-phase req/ack register-file responder behind the TinyTapeout user pins.
// Optional write parity checking is compiled in with `define BUS_PARITY_EN.
module tt_pin_bus_responder
  import tt_bus_pkg::*;
#(
  parameter logic [7:0] ID_VALUE  = 8'hA5,
  parameter int         REG_COUNT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tt_pin_bus_responder_if.slave  bus,
  output logic [1:0]             dbg_state
);
  localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(REG_COUNT - 1);

  logic              req_s2;
  logic [1:0]        state;
  logic              we_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [2:0]        count_q;
  logic              err_q;
  logic [7:0]        rdata_q;
  logic [7:0]        regs [REG_COUNT];

  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic              parity_ok;
  logic              ack;

  tt_sync2 u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.ui_in[REQ_BIT]),
    .q     (req_s2)
  );

  assign cmd_we   = bus.ui_in[WE_BIT];
  assign cmd_addr = bus.ui_in[ADDR_W-1:0];

`ifdef BUS_PARITY_EN
  logic unused_pins;
  assign unused_pins = ^bus.ui_in[4:3];
  assign parity_ok   = even_parity_ok({bus.uio_in, bus.ui_in[PAR_BIT]});
`else
  logic unused_pins;
  assign unused_pins = ^bus.ui_in[5:3];
  assign parity_ok   = 1'b1;
`endif

  // All command effects land on the edge that leaves CAPTURE, so a reset on
  // that same edge drops a pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      last_addr_q <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_s2) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          we_q        <= cmd_we;
          last_addr_q <= cmd_addr;
          count_q     <= count_q + 3'd1;
          if (cmd_we) begin
            if (!parity_ok) err_q <= 1'b1;
            else if (cmd_addr != ID_ADDR) regs[cmd_addr] <= bus.uio_in;
          end else begin
            rdata_q <= (cmd_addr == ID_ADDR) ? ID_VALUE : regs[cmd_addr];
          end
          state <= ST_ACK;
        end
        ST_ACK: begin
          if (!req_s2) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ack         = (state == ST_ACK);
  assign bus.uio_out = rdata_q;
  assign bus.uio_oe  = (ack && !we_q) ? 8'hFF : 8'h00;

  always_comb begin
    bus.uo_out          = 8'h00;
    bus.uo_out[ACK_BIT] = ack;
    bus.uo_out[ERR_BIT] = err_q;
    bus.uo_out[4:2]     = last_addr_q;
    bus.uo_out[7:5]     = count_q;
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_tt_pin_bus_responder.sv
// Directed bench for tt_pin_bus_responder; parity cases run when BUS_PARITY_EN is defined.
module tb_tt_pin_bus_responder;
  import tt_bus_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  tt_pin_bus_responder_if bus ();

  tt_pin_bus_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [7:0] exp_mem [8];
  logic [2:0] exp_cnt;
  logic       exp_err;
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
    exp_cnt = 3'd0;
    exp_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Waits (bounded) on negedges for ack to reach the given level.
  task automatic wait_ack(input logic level, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.uo_out[0] === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // driver: one full 4-phase transaction with model update and checks
  task automatic txn(input logic we, input logic [2:0] addr, input logic [7:0] data, input logic par);
    logic ok;
    logic good;
    bus.ui_in  = {1'b1, we, par, 2'b00, addr};
    bus.uio_in = data;
`ifdef BUS_PARITY_EN
    good = ~(^{data, par});
`else
    good = 1'b1;
`endif
    exp_cnt = exp_cnt + 3'd1;
    if (we) begin
      if (!good) exp_err = 1'b1;
      else if (addr != 3'd7) exp_mem[addr] = data;
    end else begin
      exp_q.push_back((addr == 3'd7) ? 8'hA5 : exp_mem[addr]);
    end
    wait_ack(1'b1, ok);
    check("ack_rise", {7'd0, ok}, 8'h01);
    check("uo_out_in_ack", bus.uo_out, {exp_cnt, addr, exp_err, 1'b1});
    if (!we) begin
      check("uio_oe_read", bus.uio_oe, 8'hFF);
      if (exp_q.size() > 0) check("read_data", bus.uio_out, exp_q.pop_front());
    end else begin
      check("uio_oe_write", bus.uio_oe, 8'h00);
    end
    bus.ui_in[7] = 1'b0;
    wait_ack(1'b0, ok);
    check("ack_fall", {7'd0, ok}, 8'h01);
    check("uio_oe_idle", bus.uio_oe, 8'h00);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] data);
    txn(1'b1, addr, data, ^data);
  endtask

  task automatic rd(input logic [2:0] addr);
    txn(1'b0, addr, 8'h00, 1'b0);
  endtask

  initial begin
    logic ok;
    logic hold_ok;
    rst_n      = 1'b0;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    model_reset();
    do_reset();

    // reset state
    check("rst_uo_out", bus.uo_out, 8'h00);
    check("rst_uio_out", bus.uio_out, 8'h00);
    check("rst_uio_oe", bus.uio_oe, 8'h00);
    check("rst_state", {6'd0, dbg_state}, {6'd0, ST_IDLE});

    // exact handshake timing: write 8'h3C to addr 2
    bus.ui_in  = 8'hC2;
    bus.uio_in = 8'h3C;
    @(negedge clk);
    check("k0_ack", {7'd0, bus.uo_out[0]}, 8'h00);
    @(negedge clk);
    check("k1_state", {6'd0, dbg_state}, {6'd0, ST_IDLE});
    @(negedge clk);
    check("k2_state", {6'd0, dbg_state}, {6'd0, ST_CAPTURE});
    check("k2_ack", {7'd0, bus.uo_out[0]}, 8'h00);
    @(negedge clk);
    check("k3_ack", {7'd0, bus.uo_out[0]}, 8'h01);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.uo_out[0] !== 1'b1) hold_ok = 1'b0;
    end
    check("ack_hold", {7'd0, hold_ok}, 8'h01);
    check("wr_uo_out", bus.uo_out, 8'h29);
    check("wr_uio_oe", bus.uio_oe, 8'h00);
    bus.ui_in[7] = 1'b0;
    @(negedge clk);
    check("j0_ack", {7'd0, bus.uo_out[0]}, 8'h01);
    @(negedge clk);
    check("j1_ack", {7'd0, bus.uo_out[0]}, 8'h01);
    @(negedge clk);
    check("j2_ack", {7'd0, bus.uo_out[0]}, 8'h00);
    exp_cnt    = 3'd1;
    exp_mem[2] = 8'h3C;

    // read back; ID register; ignored write to addr 7
    rd(3'd2);
    check("rd2_uo_out", bus.uo_out, 8'h48);
    wr(3'd7, 8'h00);
    rd(3'd7);
    check("id_err", {7'd0, bus.uo_out[1]}, 8'h00);
    wr(3'd0, 8'h5A);
    wr(3'd6, 8'hC3);
    rd(3'd0);
    rd(3'd6);
    check("wrap_cnt8", {5'd0, bus.uo_out[7:5]}, 8'h00);

    // reset while in ACK of a read of addr 2
    bus.ui_in = 8'h82;
    wait_ack(1'b1, ok);
    check("rst_ack_reached", {7'd0, ok}, 8'h01);
    rst_n = 1'b0;
    @(negedge clk);
    check("ackrst_uo_out", bus.uo_out, 8'h00);
    check("ackrst_uio_oe", bus.uio_oe, 8'h00);
    check("ackrst_uio_out", bus.uio_out, 8'h00);
    check("ackrst_state", {6'd0, dbg_state}, {6'd0, ST_IDLE});
    bus.ui_in = 8'h00;
    rst_n     = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rd(3'd2);

    // reset on the commit edge drops the write
    bus.ui_in  = 8'hC3;
    bus.uio_in = 8'h77;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (dbg_state === ST_CAPTURE) begin
        ok = 1'b1;
        break;
      end
    end
    check("capture_reached", {7'd0, ok}, 8'h01);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    bus.ui_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    rd(3'd3);

    // 9 back-to-back transactions from a fresh count
    do_reset();
    for (int i = 0; i < 7; i++) wr(3'(i), 8'(8'h10 + i));
    rd(3'd5);
    rd(3'd7);
    check("cnt9_wrap", {5'd0, bus.uo_out[7:5]}, 8'h01);

`ifdef BUS_PARITY_EN
    do_reset();
    txn(1'b1, 3'd1, 8'h01, 1'b0);
    check("par_err_set", {7'd0, bus.uo_out[1]}, 8'h01);
    rd(3'd1);
    txn(1'b1, 3'd1, 8'h01, 1'b1);
    rd(3'd1);
    check("par_err_sticky", {7'd0, bus.uo_out[1]}, 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
